// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - Device end of a 16-bit SDR SDRAM bus, serving bursts from block RAM.
// Optional: define SDRAM_RESP_PROTO_CHECK_EN for protocol checking (err/err_code, bank state, TRCD).
module sdram_responder #(
    parameter int MEM_AW = 14,
    parameter int TRCD   = 2,
    parameter int ROW_W  = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] SDRAM_A,
    input  logic [1:0]  SDRAM_BA,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic        SDRAM_DQML,
    input  logic        SDRAM_DQMH,
    input  logic        SDRAM_CKE,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic [1:0]  dq_oe,
    output logic [12:0] mode_reg,
    output logic [15:0] refresh_cnt,
    output logic        err,
    output logic [2:0]  err_code
);
    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_t;

    cmd_t              cmd;
    logic              rw_cmd;
    logic              rw_ok;
    logic [ROW_W-1:0]  bank_row [4];
    logic [2:0]        bl_mask;
    logic [2:0]        new_mask;
    logic              cl3;

    logic              burst_active;
    logic              burst_wr;
    logic              burst_step;
    logic [1:0]        burst_bank;
    logic [ROW_W-1:0]  burst_row;
    logic [8:0]        burst_col;
    logic [8:0]        burst_col_cur;
    logic [2:0]        burst_idx;
    logic [2:0]        burst_mask;

    logic              acc_en;
    logic              acc_wr;
    logic [1:0]        acc_bank;
    logic [ROW_W-1:0]  acc_row;
    logic [8:0]        acc_col;
    logic [MEM_AW-1:0] acc_addr;

    logic [7:0]        mem_lo [2**MEM_AW];
    logic [7:0]        mem_hi [2**MEM_AW];
    logic [15:0]       rd_word;
    logic [15:0]       rd_d1;
    logic [15:0]       rd_d2;
    logic              rd_v0;
    logic              rd_v1;
    logic              rd_v2;
    logic              dqml_d1;
    logic              dqml_d2;
    logic              dqmh_d1;
    logic              dqmh_d2;

    assign cmd    = (SDRAM_CKE && !SDRAM_nCS) ? cmd_t'({SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE}) : CMD_NOP;
    assign rw_cmd = (cmd == CMD_RD) || (cmd == CMD_WR);

`ifdef SDRAM_RESP_PROTO_CHECK_EN
    localparam logic [7:0] TRCD_LOAD = (TRCD > 0) ? 8'(TRCD - 1) : 8'd0;

    logic [3:0] bank_open;
    logic [7:0] trcd_cnt [4];
    logic       mode_valid;
    logic       burst_ap;
    logic [2:0] viol;

    // Reads/writes to a closed bank are dropped entirely.
    assign rw_ok = rw_cmd && bank_open[SDRAM_BA];

    always_comb begin
        viol = 3'd0;
        if (!mode_valid && cmd != CMD_NOP && cmd != CMD_PRE && cmd != CMD_LMR && cmd != CMD_REF)
            viol = 3'd1;
        else if (cmd == CMD_ACT && bank_open[SDRAM_BA])
            viol = 3'd2;
        else if (rw_cmd && !bank_open[SDRAM_BA])
            viol = 3'd3;
        else if (rw_cmd && trcd_cnt[SDRAM_BA] != 8'd0)
            viol = 3'd4;
        else if (cmd == CMD_LMR && SDRAM_A[6:4] != 3'd2 && SDRAM_A[6:4] != 3'd3)
            viol = 3'd5;
        else if (cmd == CMD_REF && |bank_open)
            viol = 3'd6;
        else if (cmd == CMD_LMR && |bank_open)
            viol = 3'd7;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_open  <= '0;
            mode_valid <= 1'b0;
            burst_ap   <= 1'b0;
            err        <= 1'b0;
            err_code   <= 3'd0;
            for (int b = 0; b < 4; b++) trcd_cnt[b] <= 8'd0;
        end else if (SDRAM_CKE) begin
            for (int b = 0; b < 4; b++)
                if (trcd_cnt[b] != 8'd0) trcd_cnt[b] <= trcd_cnt[b] - 8'd1;
            if (burst_step && burst_idx == burst_mask && burst_ap)
                bank_open[burst_bank] <= 1'b0;
            if (viol != 3'd0 && !err) begin
                err      <= 1'b1;
                err_code <= viol;
            end
            case (cmd)
                CMD_ACT: begin
                    bank_open[SDRAM_BA] <= 1'b1;
                    trcd_cnt[SDRAM_BA]  <= TRCD_LOAD;
                end
                CMD_RD, CMD_WR: begin
                    if (rw_ok) begin
                        burst_ap <= SDRAM_A[10];
                        if (new_mask == 3'd0 && SDRAM_A[10]) bank_open[SDRAM_BA] <= 1'b0;
                    end
                end
                CMD_PRE: begin
                    if (SDRAM_A[10]) bank_open <= '0;
                    else             bank_open[SDRAM_BA] <= 1'b0;
                end
                CMD_LMR: mode_valid <= 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign rw_ok    = rw_cmd;
    assign err      = 1'b0;
    assign err_code = 3'd0;
`endif

    always_comb begin
        case (mode_reg[2:0])
            3'd1:    bl_mask = 3'd1;
            3'd2:    bl_mask = 3'd3;
            3'd3:    bl_mask = 3'd7;
            default: bl_mask = 3'd0;
        endcase
    end

    assign cl3      = (mode_reg[6:4] == 3'd3);
    assign new_mask = (cmd == CMD_WR && mode_reg[9]) ? 3'd0 : bl_mask;

    // Sequential order, wrapping inside the BL-aligned block of columns.
    assign burst_col_cur = {burst_col[8:3],
                            (burst_col[2:0] & ~burst_mask) | ((burst_col[2:0] + burst_idx) & burst_mask)};
    assign burst_step    = SDRAM_CKE && burst_active && !rw_ok && cmd != CMD_BST;

    always_comb begin
        acc_en   = 1'b0;
        acc_wr   = 1'b0;
        acc_bank = SDRAM_BA;
        acc_row  = bank_row[SDRAM_BA];
        acc_col  = SDRAM_A[8:0];
        if (!reset) begin
            if (rw_ok) begin
                acc_en = 1'b1;
                acc_wr = (cmd == CMD_WR);
            end else if (burst_step) begin
                acc_en   = 1'b1;
                acc_wr   = burst_wr;
                acc_bank = burst_bank;
                acc_row  = burst_row;
                acc_col  = burst_col_cur;
            end
        end
    end

    assign acc_addr = MEM_AW'({acc_bank, acc_row, acc_col});

    always_ff @(posedge clk) begin
        if (acc_en && acc_wr) begin
            if (!SDRAM_DQML) mem_lo[acc_addr] <= dq_in[7:0];
            if (!SDRAM_DQMH) mem_hi[acc_addr] <= dq_in[15:8];
        end
        if (SDRAM_CKE) rd_word <= {mem_hi[acc_addr], mem_lo[acc_addr]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg     <= '0;
            refresh_cnt  <= '0;
            burst_active <= 1'b0;
            burst_wr     <= 1'b0;
            burst_bank   <= 2'd0;
            burst_row    <= '0;
            burst_col    <= 9'd0;
            burst_idx    <= 3'd0;
            burst_mask   <= 3'd0;
            rd_v0        <= 1'b0;
            rd_v1        <= 1'b0;
            rd_v2        <= 1'b0;
            rd_d1        <= 16'd0;
            rd_d2        <= 16'd0;
            dqml_d1      <= 1'b0;
            dqml_d2      <= 1'b0;
            dqmh_d1      <= 1'b0;
            dqmh_d2      <= 1'b0;
        end else if (SDRAM_CKE) begin
            rd_v0   <= acc_en && !acc_wr;
            rd_v1   <= rd_v0;
            rd_d1   <= rd_word;
            rd_v2   <= rd_v1;
            rd_d2   <= rd_d1;
            dqml_d1 <= SDRAM_DQML;
            dqml_d2 <= dqml_d1;
            dqmh_d1 <= SDRAM_DQMH;
            dqmh_d2 <= dqmh_d1;
            if (burst_step) begin
                burst_idx <= burst_idx + 3'd1;
                if (burst_idx == burst_mask) burst_active <= 1'b0;
            end
            case (cmd)
                CMD_ACT: bank_row[SDRAM_BA] <= SDRAM_A[ROW_W-1:0];
                CMD_RD, CMD_WR: begin
                    if (rw_ok) begin
                        burst_active <= (new_mask != 3'd0);
                        burst_wr     <= (cmd == CMD_WR);
                        burst_bank   <= SDRAM_BA;
                        burst_row    <= bank_row[SDRAM_BA];
                        burst_col    <= SDRAM_A[8:0];
                        burst_idx    <= 3'd1;
                        burst_mask   <= new_mask;
                    end
                end
                CMD_REF: refresh_cnt  <= refresh_cnt + 16'd1;
                CMD_LMR: mode_reg     <= SDRAM_A;
                CMD_BST: burst_active <= 1'b0;
                default: ;
            endcase
        end
    end

    assign dq_out = cl3 ? rd_d2 : rd_d1;
    assign dq_oe  = (cl3 ? rd_v2 : rd_v1) ? {~dqmh_d2, ~dqml_d2} : 2'b00;

endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - Directed scoreboard bench for sdram_responder.
`timescale 1ns/1ps
module tb_sdram_responder;
    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;
`ifdef SDRAM_RESP_PROTO_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] sa;
    logic [1:0]  sba;
    logic        ncs, nras, ncas, nwe, dqml, dqmh, cke;
    logic [15:0] dq_in, dq_out, refresh_cnt;
    logic [1:0]  dq_oe;
    logic [12:0] mode_reg;
    logic        err;
    logic [2:0]  err_code;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic [1:0]  oe;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    int   n_edge;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_responder dut (
        .clk(clk), .reset(reset), .SDRAM_A(sa), .SDRAM_BA(sba), .SDRAM_nCS(ncs),
        .SDRAM_nRAS(nras), .SDRAM_nCAS(ncas), .SDRAM_nWE(nwe), .SDRAM_DQML(dqml),
        .SDRAM_DQMH(dqmh), .SDRAM_CKE(cke), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
        .mode_reg(mode_reg), .refresh_cnt(refresh_cnt), .err(err), .err_code(err_code)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                        input logic [15:0] d, input logic ml, input logic mh);
        {nras, ncas, nwe} = c;
        sba   = ba;
        sa    = a;
        dq_in = d;
        dqml  = ml;
        dqmh  = mh;
        @(posedge clk);
        #1;
        {nras, ncas, nwe} = C_NOP;
        dqml = 1'b0;
        dqmh = 1'b0;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(C_NOP, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic push(input int due, input logic [15:0] data, input logic [1:0] oe);
        exp_t e;
        e.due  = due;
        e.data = data;
        e.oe   = oe;
        sb.push_back(e);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    // Data for a read at edge N is visible in the cycle after edge N+CL-1.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("rd_oe", 16'(dq_oe), 16'(mon_e.oe));
                chk("rd_data", dq_out & {{8{mon_e.oe[1]}}, {8{mon_e.oe[0]}}},
                    mon_e.data & {{8{mon_e.oe[1]}}, {8{mon_e.oe[0]}}});
            end else begin
                chk("idle_oe", 16'(dq_oe), 16'd0);
            end
        end
    end

    initial begin
        reset = 1'b1; cke = 1'b1; ncs = 1'b0; {nras, ncas, nwe} = C_NOP;
        sa = '0; sba = '0; dq_in = '0; dqml = 1'b0; dqmh = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        chk("rst_mode", 16'(mode_reg), 16'd0);
        chk("rst_refresh", refresh_cnt, 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_err_code", 16'(err_code), 16'd0);
        chk("rst_dq_out", dq_out, 16'd0);

        // Basic write/read, CL2 BL1 with single-word writes
        step(C_PRE, 2'd0, 13'h400, 16'd0, 1'b0, 1'b0);
        step(C_LMR, 2'd0, 13'h220, 16'd0, 1'b0, 1'b0);
        chk("mode_220", 16'(mode_reg), 16'h0220);
        step(C_ACT, 2'd1, 13'h0123, 16'd0, 1'b0, 1'b0);
        nop(1);
        step(C_WR, 2'd1, 13'h045, 16'hBEEF, 1'b0, 1'b0);
        step(C_RD, 2'd1, 13'h045, 16'd0, 1'b0, 1'b0);
        n_edge = cyc;
        push(n_edge + 1, 16'hBEEF, 2'b11);
        nop(3);
        chk("err_clean", 16'(err), 16'd0);

        // High byte masked on write
        step(C_WR, 2'd1, 13'h045, 16'h1234, 1'b0, 1'b1);
        step(C_RD, 2'd1, 13'h045, 16'd0, 1'b0, 1'b0);
        n_edge = cyc;
        push(n_edge + 1, 16'hBE34, 2'b11);
        nop(3);

        // CL3 BL4 wrapped burst with a read-masked second word
        for (int i = 4; i < 8; i++)
            step(C_WR, 2'd1, 13'(i), 16'hC000 + 16'(i), 1'b0, 1'b0);
        step(C_PRE, 2'd0, 13'h400, 16'd0, 1'b0, 1'b0);
        step(C_LMR, 2'd0, 13'h032, 16'd0, 1'b0, 1'b0);
        chk("mode_032", 16'(mode_reg), 16'h0032);
        step(C_ACT, 2'd1, 13'h0123, 16'd0, 1'b0, 1'b0);
        nop(1);
        step(C_RD, 2'd1, 13'h006, 16'd0, 1'b0, 1'b0);
        n_edge = cyc;
        push(n_edge + 2, 16'hC006, 2'b11);
        push(n_edge + 3, 16'hC007, 2'b01);
        push(n_edge + 4, 16'hC004, 2'b11);
        push(n_edge + 5, 16'hC005, 2'b11);
        nop(1);
        step(C_NOP, 2'd0, 13'd0, 16'd0, 1'b0, 1'b1);
        nop(6);
        chk("err_after_burst", 16'(err), 16'd0);

        // Refresh counter wrap, then refresh with a bank open
        step(C_PRE, 2'd0, 13'h400, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
        chk("refresh_wrap", refresh_cnt, 16'd4464);
        chk("err_refresh_closed", 16'(err), 16'd0);
        step(C_ACT, 2'd2, 13'h0010, 16'd0, 1'b0, 1'b0);
        step(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
        chk("refresh_open_cnt", refresh_cnt, 16'd4465);
        chk("err_ref_open", 16'(err), 16'(CHK));
        chk("err_code_ref_open", 16'(err_code), CHK ? 16'd6 : 16'd0);

        // Closed-bank read, then a too-early read that must not overwrite the first code
        pulse_reset();
        chk("rst2_refresh", refresh_cnt, 16'd0);
        chk("rst2_err", 16'(err), 16'd0);
        step(C_PRE, 2'd0, 13'h400, 16'd0, 1'b0, 1'b0);
        step(C_LMR, 2'd0, 13'h020, 16'd0, 1'b0, 1'b0);
        step(C_RD, 2'd0, 13'h045, 16'd0, !CHK, !CHK);
        nop(3);
        chk("err_closed", 16'(err), 16'(CHK));
        chk("err_code_closed", 16'(err_code), CHK ? 16'd3 : 16'd0);
        step(C_ACT, 2'd0, 13'h0003, 16'd0, 1'b0, 1'b0);
        step(C_RD, 2'd0, 13'h045, 16'd0, 1'b0, 1'b0);
        n_edge = cyc;
        push(n_edge + 1, 16'hBE34, 2'b11);
        nop(3);
        chk("err_code_sticky", 16'(err_code), CHK ? 16'd3 : 16'd0);

        // Reset during the second word of a CL3 BL8 burst
        step(C_PRE, 2'd0, 13'h400, 16'd0, 1'b0, 1'b0);
        step(C_LMR, 2'd0, 13'h033, 16'd0, 1'b0, 1'b0);
        step(C_ACT, 2'd1, 13'h0123, 16'd0, 1'b0, 1'b0);
        nop(1);
        step(C_RD, 2'd1, 13'h004, 16'd0, 1'b0, 1'b0);
        n_edge = cyc;
        push(n_edge + 2, 16'hC004, 2'b11);
        push(n_edge + 3, 16'hC005, 2'b11);
        nop(3);
        pulse_reset();
        chk("abort_oe", 16'(dq_oe), 16'd0);
        chk("abort_mode", 16'(mode_reg), 16'd0);
        chk("abort_err", 16'(err), 16'd0);
        step(C_RD, 2'd1, 13'h004, 16'd0, !CHK, !CHK);
        nop(3);
        chk("err_no_mode", 16'(err), 16'(CHK));
        chk("err_code_no_mode", 16'(err_code), CHK ? 16'd1 : 16'd0);

        nop(4);
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
